// File: rtl/sensors_collector.sv
// Collects per-slot sensor samples into a shadow image and publishes it atomically on commit.
// Optional per-slot staleness aging is compiled in with SENSORS_AGING_EN.
module sensors_collector #(
    parameter int width   = 200,
    parameter int timeout = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    input  logic [7:0]           sample_id_i,
    input  logic [7:0]           sample_temp_i,
    input  logic                 sample_off_i,
    input  logic                 frame_commit_i,
    output logic [8*width-1:0]   sensors_data_o,
    output logic [width-1:0]     sensors_en_o,
    output logic                 frame_valid_o,
    output logic                 err_id_o
);

    if (width < 1 || width > 255 || timeout < 1 || timeout > 255) begin : g_bad_param
        $error("sensors_collector: width and timeout must be in 1..255");
    end

    typedef enum logic {ACCEPT = 1'b0, COMMIT = 1'b1} state_t;

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [8*width-1:0]   shadow_data_q, shadow_data_d;
    logic [width-1:0]     shadow_en_q, shadow_en_d;
    logic [8*width-1:0]   pub_data_q, pub_data_d;
    logic [width-1:0]     pub_en_q, pub_en_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 err_id_q, err_id_d;
    logic                 xfer;
    logic                 id_ok;

`ifdef SENSORS_AGING_EN
    localparam logic [7:0] AGE_MAX = 8'(timeout);
    logic [7:0] age_q [width];
    logic [7:0] age_d [width];
`endif

    assign xfer  = sample_valid_i & ready_q;
    assign id_ok = int'(sample_id_i) < width;

    always_comb begin
        state_d       = state_q;
        shadow_data_d = shadow_data_q;
        shadow_en_d   = shadow_en_q;
        pub_data_d    = pub_data_q;
        pub_en_d      = pub_en_q;
        frame_valid_d = 1'b0;
        err_id_d      = err_id_q | (xfer & ~id_ok);
`ifdef SENSORS_AGING_EN
        age_d         = age_q;
`endif

        // An out-of-range ID never matches a slot, so the shadow is left alone.
        for (int i = 0; i < width; i++) begin
            if (xfer && sample_id_i == 8'(i)) begin
                if (!sample_off_i) begin
                    shadow_data_d[8*i +: 8] = sample_temp_i;
                end
                shadow_en_d[i] = ~sample_off_i;
`ifdef SENSORS_AGING_EN
                age_d[i] = 8'd0;
`endif
            end
`ifdef SENSORS_AGING_EN
            else if (shadow_en_q[i]) begin
                if (age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + 8'd1;
                end
                if (age_d[i] == AGE_MAX) begin
                    shadow_en_d[i] = 1'b0;
                end
            end
`endif
        end

        case (state_q)
            ACCEPT: begin
                if (frame_commit_i) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                pub_data_d    = shadow_data_q;
                pub_en_d      = shadow_en_q;
                frame_valid_d = 1'b1;
                state_d       = ACCEPT;
            end
            default: state_d = ACCEPT;
        endcase

        ready_d = (state_d == ACCEPT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ACCEPT;
            ready_q       <= 1'b1;
            shadow_data_q <= '0;
            shadow_en_q   <= '0;
            pub_data_q    <= '0;
            pub_en_q      <= '0;
            frame_valid_q <= 1'b0;
            err_id_q      <= 1'b0;
`ifdef SENSORS_AGING_EN
            for (int i = 0; i < width; i++) begin
                age_q[i] <= 8'd0;
            end
`endif
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            shadow_data_q <= shadow_data_d;
            shadow_en_q   <= shadow_en_d;
            pub_data_q    <= pub_data_d;
            pub_en_q      <= pub_en_d;
            frame_valid_q <= frame_valid_d;
            err_id_q      <= err_id_d;
`ifdef SENSORS_AGING_EN
            for (int i = 0; i < width; i++) begin
                age_q[i] <= age_d[i];
            end
`endif
        end
    end

    assign sample_ready_o = ready_q;
    assign sensors_data_o = pub_data_q;
    assign sensors_en_o   = pub_en_q;
    assign frame_valid_o  = frame_valid_q;
    assign err_id_o       = err_id_q;

endmodule

// File: tb/tb_sensors_collector.sv
// Randomised and directed bench for sensors_collector against a timestamp-based image model.
module tb_sensors_collector;
    localparam int W  = 200;
    localparam int TO = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             sample_valid_i = 1'b0;
    logic             sample_ready_o;
    logic [7:0]       sample_id_i = '0;
    logic [7:0]       sample_temp_i = '0;
    logic             sample_off_i = 1'b0;
    logic             frame_commit_i = 1'b0;
    logic [8*W-1:0]   sensors_data_o;
    logic [W-1:0]     sensors_en_o;
    logic             frame_valid_o;
    logic             err_id_o;

    always #5 clk_i = ~clk_i;

    sensors_collector #(.width(W), .timeout(TO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .sample_id_i    (sample_id_i),
        .sample_temp_i  (sample_temp_i),
        .sample_off_i   (sample_off_i),
        .frame_commit_i (frame_commit_i),
        .sensors_data_o (sensors_data_o),
        .sensors_en_o   (sensors_en_o),
        .frame_valid_o  (frame_valid_o),
        .err_id_o       (err_id_o)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Model: shadow and published images, per-slot time of last write, pending publish.
    logic [7:0] sh_data  [W];
    bit         sh_en    [W];
    int         last_wr  [W];
    logic [7:0] pub_data [W];
    bit         pub_en   [W];
    bit         m_err, m_commit, m_fv;
    int         cyc = 0;

    function automatic logic [8*W-1:0] exp_data();
        logic [8*W-1:0] r;
        for (int i = 0; i < W; i++) r[8*i +: 8] = pub_data[i];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_en();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = pub_en[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            sh_data[i] = '0; sh_en[i] = 0; last_wr[i] = 0;
            pub_data[i] = '0; pub_en[i] = 0;
        end
        m_err = 0; m_commit = 0; m_fv = 0;
    endtask

    // One clock cycle: drive at the low phase, update the model at the edge, compare at the next low phase.
    task automatic do_cycle(input bit v, input logic [7:0] id, input logic [7:0] temp,
                            input bit off, input bit cm);
        logic exp_rdy;
        exp_rdy = !m_commit;
        n_run++;
        if (sample_ready_o !== exp_rdy) begin
            n_fail++; $display("FAIL ready: got %b want %b", sample_ready_o, exp_rdy);
        end
        sample_valid_i = v; sample_id_i = id; sample_temp_i = temp;
        sample_off_i = off; frame_commit_i = cm;
        @(posedge clk_i);
        cyc++;
        if (m_commit) begin
            for (int i = 0; i < W; i++) begin pub_data[i] = sh_data[i]; pub_en[i] = sh_en[i]; end
            m_fv = 1; m_commit = 0;
        end else begin
            m_fv = 0;
            if (v) begin
                if (int'(id) < W) begin
                    if (!off) sh_data[id] = temp;
                    sh_en[id] = !off;
                    last_wr[id] = cyc;
                end else begin
                    m_err = 1;
                end
            end
            if (cm) m_commit = 1;
        end
`ifdef SENSORS_AGING_EN
        for (int i = 0; i < W; i++)
            if (sh_en[i] && (cyc - last_wr[i]) >= TO) sh_en[i] = 0;
`endif
        @(negedge clk_i);
        sample_valid_i = 0; frame_commit_i = 0;
        n_run += 4;
        if (sensors_data_o !== exp_data()) begin
            n_fail++; $display("FAIL data: got %h want %h", sensors_data_o, exp_data());
        end
        if (sensors_en_o !== exp_en()) begin
            n_fail++; $display("FAIL en: got %h want %h", sensors_en_o, exp_en());
        end
        if (frame_valid_o !== m_fv) begin
            n_fail++; $display("FAIL frame_valid: got %b want %b", frame_valid_o, m_fv);
        end
        if (err_id_o !== m_err) begin
            n_fail++; $display("FAIL err_id: got %b want %b", err_id_o, m_err);
        end
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        #2;
        model_reset();
        n_run += 5;
        if (sample_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", sample_ready_o); end
        if (sensors_data_o !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", sensors_data_o); end
        if (sensors_en_o !== '0) begin n_fail++; $display("FAIL rst_en: got %h want 0", sensors_en_o); end
        if (frame_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_fv: got %b want 0", frame_valid_o); end
        if (err_id_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_id_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_scenario1();
        logic [W-1:0] want_en;
        want_en = '0; want_en[3] = 1'b1;
        do_cycle(1, 8'd3, 8'h19, 0, 0);
        n_run++;
        if (sensors_en_o !== '0) begin n_fail++; $display("FAIL s1_nopub: got %h want 0", sensors_en_o); end
        do_cycle(0, 8'd0, 8'h00, 0, 1);
        do_cycle(0, 8'd0, 8'h00, 0, 0);
        n_run += 3;
        if (sensors_en_o !== want_en) begin n_fail++; $display("FAIL s1_en: got %h want %h", sensors_en_o, want_en); end
        if (sensors_data_o[31:24] !== 8'h19) begin n_fail++; $display("FAIL s1_data: got %h want 19", sensors_data_o[31:24]); end
        if (frame_valid_o !== 1'b1) begin n_fail++; $display("FAIL s1_fv: got %b want 1", frame_valid_o); end
        do_cycle(0, 8'd0, 8'h00, 0, 0);
        n_run++;
        if (frame_valid_o !== 1'b0) begin n_fail++; $display("FAIL s1_fv_end: got %b want 0", frame_valid_o); end
    endtask

    task automatic test_same_cycle();
        do_cycle(1, 8'd5, 8'd40, 0, 1);
        n_run++;
        if (sample_ready_o !== 1'b0) begin n_fail++; $display("FAIL s2_ready: got %b want 0", sample_ready_o); end
        do_cycle(0, 8'd0, 8'h00, 0, 0);
        n_run += 3;
        if (sensors_data_o[47:40] !== 8'd40) begin n_fail++; $display("FAIL s2_data: got %0d want 40", sensors_data_o[47:40]); end
        if (sensors_en_o[5] !== 1'b1) begin n_fail++; $display("FAIL s2_en: got %b want 1", sensors_en_o[5]); end
        if (frame_valid_o !== 1'b1) begin n_fail++; $display("FAIL s2_fv: got %b want 1", frame_valid_o); end
    endtask

    task automatic test_off();
        do_cycle(1, 8'd3, 8'h77, 1, 0);
        do_cycle(0, 8'd0, 8'h00, 0, 1);
        do_cycle(0, 8'd0, 8'h00, 0, 0);
        n_run += 2;
        if (sensors_en_o[3] !== 1'b0) begin n_fail++; $display("FAIL s3_en: got %b want 0", sensors_en_o[3]); end
        if (sensors_data_o[31:24] !== 8'h19) begin n_fail++; $display("FAIL s3_data: got %h want 19", sensors_data_o[31:24]); end
    endtask

    task automatic test_bad_id();
        do_cycle(1, 8'd200, 8'hEE, 0, 1);
        do_cycle(0, 8'd0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) do_cycle(0, 8'd0, 8'h00, 0, 0);
        n_run++;
        if (err_id_o !== 1'b1) begin n_fail++; $display("FAIL s4_err_hold: got %b want 1", err_id_o); end
    endtask

    task automatic test_reset_in_commit();
        do_cycle(1, 8'd7, 8'hAA, 0, 1);
        #2 rst_i = 1'b1;
        #1;
        n_run += 4;
        if (sensors_data_o !== '0) begin n_fail++; $display("FAIL s5_data: got %h want 0", sensors_data_o); end
        if (sensors_en_o !== '0) begin n_fail++; $display("FAIL s5_en: got %h want 0", sensors_en_o); end
        if (frame_valid_o !== 1'b0) begin n_fail++; $display("FAIL s5_fv: got %b want 0", frame_valid_o); end
        if (err_id_o !== 1'b0) begin n_fail++; $display("FAIL s5_err: got %b want 0", err_id_o); end
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_run++;
        if (sample_ready_o !== 1'b1) begin n_fail++; $display("FAIL s5_ready: got %b want 1", sample_ready_o); end
        do_cycle(0, 8'd0, 8'h00, 0, 1);
        do_cycle(0, 8'd0, 8'h00, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            do_cycle(($urandom_range(0, 2) != 0),
                     8'($urandom_range(0, W + 9)),
                     8'($urandom),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 5) == 0));
        end
    endtask

`ifdef SENSORS_AGING_EN
    task automatic test_aging();
        do_cycle(1, 8'd0, 8'h33, 0, 0);
        for (int i = 0; i < TO; i++) do_cycle(0, 8'd0, 8'h00, 0, 0);
        do_cycle(0, 8'd0, 8'h00, 0, 1);
        do_cycle(0, 8'd0, 8'h00, 0, 0);
        n_run++;
        if (sensors_en_o[0] !== 1'b0) begin n_fail++; $display("FAIL s6_stale: got %b want 0", sensors_en_o[0]); end
        do_cycle(1, 8'd0, 8'h44, 0, 0);
        for (int r = 0; r < 4; r++) begin
            do_cycle(0, 8'd0, 8'h00, 0, 0);
            do_cycle(0, 8'd0, 8'h00, 0, 0);
            do_cycle(1, 8'd0, 8'h44, 0, 0);
        end
        do_cycle(0, 8'd0, 8'h00, 0, 1);
        do_cycle(0, 8'd0, 8'h00, 0, 0);
        n_run++;
        if (sensors_en_o[0] !== 1'b1) begin n_fail++; $display("FAIL s6_fresh: got %b want 1", sensors_en_o[0]); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_scenario1();
        test_same_cycle();
        test_off();
        test_bad_id();
        test_reset_in_commit();
        test_random();
`ifdef SENSORS_AGING_EN
        test_aging();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
